// File: rtl/vlane_store_buff.sv
// vlane_store_buff: per-lane VRF->DDR store buffer. All lanes write one row in parallel,
// then elements drain lane-fastest and are packed SEW-wide into AXI-stream beats.
module vlane_store_buff #(
    parameter int V_LANE_NUM         = 8,
    parameter int BUFF_DEPTH         = 256,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int VL_W               = $clog2(V_LANE_NUM*BUFF_DEPTH)+1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      cfg_sew,
    input  logic [VL_W-1:0]                 cfg_vl,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    input  logic                            vlane_wvalid,
    output logic                            vlane_wready,
    input  logic [V_LANE_NUM*32-1:0]        vlane_store_data,
    output logic                            rd_tvalid,
    input  logic                            rd_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_tdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] rd_tkeep,
    output logic                            rd_tlast
);
    localparam int N   = V_LANE_NUM;
    localparam int DW  = C_M_AXI_DATA_WIDTH;
    localparam int KW  = DW/8;
    localparam int LW  = $clog2(N);
    localparam int RW  = $clog2(BUFF_DEPTH);
    localparam int OW  = $clog2(KW);
    localparam int CAP = N*BUFF_DEPTH;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

    state_t          state_q;
    logic            busy_q, done_q, wready_q;
    logic [1:0]      sew_sh_q;
    logic [OW:0]     epb_q;
    logic [VL_W-1:0] vl_q;
    logic [RW:0]     rows_q, wr_row_q;
    logic [VL_W-1:0] rd_e_q;
    logic [OW:0]     slot_q;
    logic [2:0]      credit_q;

    logic            s1_vld_q, s1_eob_q, s1_last_q;
    logic [LW-1:0]   s1_lane_q;
    logic [OW-1:0]   s1_off_q;
    logic            s2_vld_q, s2_eob_q, s2_last_q;
    logic [31:0]     s2_data_q;
    logic [OW-1:0]   s2_off_q;
    logic [DW-1:0]   acc_data_q;
    logic [KW-1:0]   acc_keep_q;

    logic [DW-1:0]   fifo_data_q [4];
    logic [KW-1:0]   fifo_keep_q [4];
    logic [3:0]      fifo_last_q;
    logic [1:0]      wp_q, rp_q;
    logic [2:0]      cnt_q;

    logic [31:0]     mem_q [N][BUFF_DEPTH];
    logic [31:0]     lane_dout_q [N];

    logic [VL_W-1:0] vl_in;
    logic [RW:0]     rows_in;
    logic [1:0]      sew_sh_in;
    logic            wr_en, issue, new_beat, last_elem, eob, pop, push;
    logic [LW-1:0]   rd_lane;
    logic [RW-1:0]   rd_row;
    logic [OW-1:0]   issue_off;
    logic [31:0]     elem;
    logic [KW-1:0]   elem_keep;
    logic [DW-1:0]   beat_data;
    logic [KW-1:0]   beat_keep;

    always_comb begin
        vl_in   = (cfg_vl > VL_W'(CAP)) ? VL_W'(CAP) : cfg_vl;
        rows_in = (RW+1)'((vl_in + VL_W'(N-1)) >> LW);
        case (cfg_sew)
            2'd0:    sew_sh_in = 2'd0;
            2'd1:    sew_sh_in = 2'd1;
            default: sew_sh_in = 2'd2;
        endcase
    end

    assign wr_en     = wready_q && vlane_wvalid;
    assign last_elem = (rd_e_q == vl_q - VL_W'(1));
    assign eob       = (slot_q == epb_q - (OW+1)'(1)) || last_elem;
    // A new beat is started only when a FIFO slot is reserved for it; later elements of
    // the same beat ride on that reservation.
    assign issue     = (state_q == S_DRAIN) && (rd_e_q < vl_q) &&
                       ((slot_q != '0) || (credit_q < 3'd4));
    assign new_beat  = issue && (slot_q == '0);
    assign rd_lane   = rd_e_q[LW-1:0];
    assign rd_row    = rd_e_q[LW +: RW];
    assign issue_off = OW'(slot_q << sew_sh_q);
    assign pop       = rd_tvalid && rd_tready;
    assign push      = s2_vld_q && s2_eob_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wready_q <= 1'b0;
            sew_sh_q <= '0;
            epb_q    <= '0;
            vl_q     <= '0;
            rows_q   <= '0;
            wr_row_q <= '0;
            rd_e_q   <= '0;
            slot_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sew_sh_q <= sew_sh_in;
                        epb_q    <= (OW+1)'(KW >> sew_sh_in);
                        vl_q     <= vl_in;
                        rows_q   <= rows_in;
                        wr_row_q <= '0;
                        rd_e_q   <= '0;
                        slot_q   <= '0;
                        if (vl_in == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_FILL;
                            busy_q   <= 1'b1;
                            wready_q <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (wr_en) begin
                        wr_row_q <= wr_row_q + (RW+1)'(1);
                        if (wr_row_q == rows_q - (RW+1)'(1)) begin
                            state_q  <= S_DRAIN;
                            wready_q <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (issue) begin
                        rd_e_q <= rd_e_q + VL_W'(1);
                        slot_q <= eob ? '0 : slot_q + (OW+1)'(1);
                    end
                    if (pop && fifo_last_q[rp_q]) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Lane RAMs plus their output registers form the first read stage; no reset.
    always_ff @(posedge clk) begin
        for (int l = 0; l < N; l++) begin
            if (wr_en)
                mem_q[l][wr_row_q[RW-1:0]] <= vlane_store_data[32*l +: 32];
            if (issue)
                lane_dout_q[l] <= mem_q[l][rd_row];
        end
    end

    always_comb begin
        case (sew_sh_q)
            2'd0: begin
                elem      = {24'd0, s2_data_q[7:0]};
                elem_keep = KW'(4'b0001);
            end
            2'd1: begin
                elem      = {16'd0, s2_data_q[15:0]};
                elem_keep = KW'(4'b0011);
            end
            default: begin
                elem      = s2_data_q;
                elem_keep = KW'(4'b1111);
            end
        endcase
        beat_data = acc_data_q | (DW'(elem) << {s2_off_q, 3'b000});
        beat_keep = acc_keep_q | (elem_keep << s2_off_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_eob_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_lane_q   <= '0;
            s1_off_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_eob_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_data_q   <= '0;
            s2_off_q    <= '0;
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            fifo_last_q <= '0;
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            credit_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= '0;
                fifo_keep_q[i] <= '0;
            end
        end else begin
            s1_vld_q <= issue;
            if (issue) begin
                s1_lane_q <= rd_lane;
                s1_off_q  <= issue_off;
                s1_eob_q  <= eob;
                s1_last_q <= last_elem;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_data_q <= lane_dout_q[s1_lane_q];
                s2_off_q  <= s1_off_q;
                s2_eob_q  <= s1_eob_q;
                s2_last_q <= s1_last_q;
            end
            if (s2_vld_q) begin
                if (s2_eob_q) begin
                    acc_data_q        <= '0;
                    acc_keep_q        <= '0;
                    fifo_data_q[wp_q] <= beat_data;
                    fifo_keep_q[wp_q] <= beat_keep;
                    fifo_last_q[wp_q] <= s2_last_q;
                    wp_q              <= wp_q + 2'd1;
                end else begin
                    acc_data_q <= beat_data;
                    acc_keep_q <= beat_keep;
                end
            end
            if (pop)
                rp_q <= rp_q + 2'd1;
            cnt_q    <= cnt_q + 3'(push) - 3'(pop);
            credit_q <= credit_q + 3'(new_beat) - 3'(pop);
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign vlane_wready = wready_q;
    assign rd_tvalid    = (cnt_q != 3'd0);
    assign rd_tdata     = rd_tvalid ? fifo_data_q[rp_q] : '0;
    assign rd_tkeep     = rd_tvalid ? fifo_keep_q[rp_q] : '0;
    assign rd_tlast     = rd_tvalid && fifo_last_q[rp_q];

endmodule

// File: tb/tb_vlane_store_buff.sv
// Bench for vlane_store_buff: directed and random operations checked against a byte-stream
// model of the packed output.
module tb_vlane_store_buff;
    localparam int N     = 8;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int KW    = DW/8;
    localparam int CAP   = N*DEPTH;
    localparam int VL_W  = $clog2(CAP)+1;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        cfg_sew;
    logic [VL_W-1:0]   cfg_vl;
    logic              start;
    logic              busy, done;
    logic              vlane_wvalid, vlane_wready;
    logic [N*32-1:0]   vlane_store_data;
    logic              rd_tvalid, rd_tready, rd_tlast;
    logic [DW-1:0]     rd_tdata;
    logic [KW-1:0]     rd_tkeep;

    always #5 clk = ~clk;

    vlane_store_buff #(
        .V_LANE_NUM(N), .BUFF_DEPTH(DEPTH), .C_M_AXI_DATA_WIDTH(DW), .VL_W(VL_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_sew(cfg_sew), .cfg_vl(cfg_vl), .start(start),
        .busy(busy), .done(done), .vlane_wvalid(vlane_wvalid), .vlane_wready(vlane_wready),
        .vlane_store_data(vlane_store_data), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready),
        .rd_tdata(rd_tdata), .rd_tkeep(rd_tkeep), .rd_tlast(rd_tlast)
    );

    int vectors = 0;
    int errors  = 0;

    logic [31:0] rowdata [DEPTH][N];
    logic [DW-1:0] exp_data[$], got_data[$];
    logic [KW-1:0] exp_keep[$], got_keep[$];
    logic          exp_last[$], got_last[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_busy"},   64'(busy), 0);
        chk({pfx, "_done"},   64'(done), 0);
        chk({pfx, "_wready"}, 64'(vlane_wready), 0);
        chk({pfx, "_tvalid"}, 64'(rd_tvalid), 0);
        chk({pfx, "_tlast"},  64'(rd_tlast), 0);
        chk({pfx, "_tdata"},  64'(rd_tdata), 0);
        chk({pfx, "_tkeep"},  64'(rd_tkeep), 0);
    endtask

    task automatic cmp_beats(input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("data[%0d]", i), 64'(got_data[i]), 64'(exp_data[i]));
            chk($sformatf("keep[%0d]", i), 64'(got_keep[i]), 64'(exp_keep[i]));
            chk($sformatf("last[%0d]", i), 64'(got_last[i]), 64'(exp_last[i]));
        end
    endtask

    // mode: 0 random words, 1 word = row<<8|lane, 2 low byte = element index
    task automatic run_op(input int sew, input int vlc, input int rpct, input int wpct,
                          input int mode, input int rst_after, input bit inject);
        int vl, sb, epb, rows, nb, sent, got_n, done_cyc, ndone, lh, fh, first_tv, drain_cyc;
        bit finished, stall, saw_wr, saw_tv, injected;
        logic [DW-1:0] hd, d;
        logic [KW-1:0] hk, k;
        logic hl;
        logic [31:0] w;
        logic [7:0] bq[$];

        vl   = (vlc > CAP) ? CAP : vlc;
        sb   = (sew == 0) ? 1 : (sew == 1) ? 2 : 4;
        epb  = KW / sb;
        rows = (vl + N - 1) / N;
        for (int r = 0; r < DEPTH; r++)
            for (int l = 0; l < N; l++) begin
                w = $urandom;
                if (mode == 1) w = (r << 8) | l;
                if (mode == 2) w[7:0] = 8'(r*N + l);
                rowdata[r][l] = w;
            end

        bq.delete();
        exp_data.delete(); exp_keep.delete(); exp_last.delete();
        got_data.delete(); got_keep.delete(); got_last.delete();
        for (int e = 0; e < vl; e++) begin
            w = rowdata[e/N][e%N];
            for (int b = 0; b < sb; b++) bq.push_back(w[8*b +: 8]);
        end
        nb = (bq.size() + KW - 1) / KW;
        for (int i = 0; i < nb; i++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < KW; j++)
                if (i*KW + j < bq.size()) begin
                    d[8*j +: 8] = bq[i*KW + j];
                    k[j] = 1'b1;
                end
            exp_data.push_back(d);
            exp_keep.push_back(k);
            exp_last.push_back(i == nb-1);
        end

        sent = 0; got_n = 0; done_cyc = -1; ndone = 0; lh = -1; fh = -1;
        first_tv = -1; drain_cyc = -1;
        finished = 0; stall = 0; saw_wr = 0; saw_tv = 0; injected = 0;
        hd = '0; hk = '0; hl = 0;

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                cfg_sew = 2'(sew);
                cfg_vl  = VL_W'(vlc);
                start   = 1'b1;
            end else if (inject && !injected && got_n == 10) begin
                cfg_vl   = VL_W'(5);
                start    = 1'b1;
                injected = 1;
            end else begin
                start = 1'b0;
            end
            rd_tready    = ($urandom_range(0, 99) < rpct);
            vlane_wvalid = ($urandom_range(0, 99) < wpct);
            for (int l = 0; l < N; l++)
                vlane_store_data[32*l +: 32] = (sent < DEPTH) ? rowdata[sent][l] : $urandom;

            if (rst_after > 0 && got_n == rst_after) begin
                rst = 1'b1;
                #1;
                chk_idle_outputs("mid_rst");
                cmp_beats(rst_after);
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                vlane_wvalid = 1'b0;
                rd_tready = 1'b0;
                return;
            end
            #1;

            if (stall) begin
                chk("stall_tvalid", 64'(rd_tvalid), 1);
                chk("stall_tdata", 64'(rd_tdata), 64'(hd));
                chk("stall_tkeep", 64'(rd_tkeep), 64'(hk));
                chk("stall_tlast", 64'(rd_tlast), 64'(hl));
            end
            stall = rd_tvalid && !rd_tready;
            hd = rd_tdata; hk = rd_tkeep; hl = rd_tlast;

            if (vlane_wready) saw_wr = 1;
            if (rd_tvalid) begin
                saw_tv = 1;
                if (first_tv < 0) first_tv = cyc;
            end
            if (vlane_wready && vlane_wvalid) begin
                sent++;
                if (sent == rows) drain_cyc = cyc + 1;
            end
            if (rd_tvalid && rd_tready) begin
                got_data.push_back(rd_tdata);
                got_keep.push_back(rd_tkeep);
                got_last.push_back(rd_tlast);
                got_n++;
                lh = cyc;
                if (fh < 0) fh = cyc;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end else if (ndone > 0) begin
                finished = 1;
            end
        end
        start = 1'b0;
        vlane_wvalid = 1'b0;

        chk("op_completes", 64'(finished), 1);
        chk("done_width", 64'(ndone), 1);
        chk("rows_accepted", 64'(sent), 64'(rows));
        chk("beat_count", 64'(got_n), 64'(nb));
        cmp_beats((got_n < nb) ? got_n : nb);
        if (vl == 0) begin
            chk("zl_wready_seen", 64'(saw_wr), 0);
            chk("zl_tvalid_seen", 64'(saw_tv), 0);
            // done must follow the start within two cycles
            chk("zl_done_latency", 64'(done_cyc >= 1 && done_cyc <= 2), 1);
        end else begin
            chk("done_after_last", 64'(done_cyc), 64'(lh + 1));
            chk("first_tvalid_lat",
                64'(first_tv >= drain_cyc && first_tv - drain_cyc <= epb + 3), 1);
            if (rpct >= 100 && sb == 4)
                chk("full_throughput", 64'(lh - fh), 64'(nb - 1));
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_sew = '0;
        cfg_vl = '0;
        start = 1'b0;
        vlane_wvalid = 1'b0;
        vlane_store_data = '0;
        rd_tready = 1'b0;
        #1;
        chk_idle_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_op(2, 16, 100, 100, 1, 0, 0);   // word streaming
        run_op(0, 10, 100, 100, 2, 0, 0);   // byte packing
        run_op(1, 64, 30, 70, 0, 0, 0);     // backpressure at full capacity
        run_op(2, 0, 100, 100, 0, 0, 0);    // zero length
        run_op(2, 16, 100, 100, 0, 5, 0);   // reset after 5 beats
        run_op(2, 8, 100, 100, 0, 0, 0);
        run_op(2, 100, 60, 100, 0, 0, 1);   // clamp plus ignored start
        run_op(3, 13, 100, 100, 0, 0, 0);   // sew code 3 acts as 32b
        for (int i = 0; i < 8; i++)
            run_op($urandom_range(0, 3), $urandom_range(1, 70), $urandom_range(20, 100),
                   $urandom_range(30, 100), 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
